// File: rtl/draw_wburst.sv
// AXI4 write-burst engine: splits a span (start address + word count) into
// bursts bounded by C_MAX_BURST beats and 4 KB pages, one burst in flight.
module draw_wburst #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_MAX_BURST        = 16
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic                              REQ_VALID,
  output logic                              REQ_READY,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     REQ_ADDR,
  input  logic [11:0]                       REQ_WORDS,
  input  logic                              DIN_VALID,
  output logic                              DIN_READY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     DIN_DATA,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   DIN_STRB,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [7:0]                        M_AXI_AWLEN,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WLAST,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic                              BUSY,
  output logic                              DONE,
  output logic                              ERR
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_FIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [11:0]   rem_q, rem_d;
  logic [10:0]   blen_q, blen_d;
  logic [8:0]    beat_q, beat_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic [7:0]    awlen_q, awlen_d;
  logic          err_q, err_d;

  logic [AW-1:0] req_aligned, next_addr;
  logic [11:0]   next_rem;
  logic [10:0]   blen_n;
  logic          w_hs;

  // Beats allowed from a word index within the 4 KB page: min(rem, max, room).
  function automatic logic [10:0] calc_blen(input logic [9:0] widx, input logic [11:0] rem);
    logic [10:0] room, cap;
    room = 11'd1024 - {1'b0, widx};
    cap  = (rem > 12'(C_MAX_BURST)) ? 11'(C_MAX_BURST) : rem[10:0];
    return (cap < room) ? cap : room;
  endfunction

  assign req_aligned = REQ_ADDR & {{(AW-2){1'b1}}, 2'b00};
  assign next_addr   = addr_q + {{(AW-13){1'b0}}, blen_q, 2'b00};
  assign next_rem    = rem_q - {1'b0, blen_q};
  assign w_hs        = (state_q == S_DATA) && DIN_VALID && M_AXI_WREADY;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    blen_d   = blen_q;
    beat_d   = beat_q;
    awaddr_d = awaddr_q;
    awlen_d  = awlen_q;
    err_d    = err_q;
    blen_n   = '0;
    case (state_q)
      S_IDLE: if (REQ_VALID) begin
        addr_d = req_aligned;
        rem_d  = REQ_WORDS;
        err_d  = 1'b0;
        if (REQ_WORDS == 12'd0) state_d = S_FIN;
        else begin
          blen_n   = calc_blen(req_aligned[11:2], REQ_WORDS);
          blen_d   = blen_n;
          awaddr_d = req_aligned;
          awlen_d  = blen_n[7:0] - 8'd1;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: if (M_AXI_AWREADY) begin
        beat_d  = blen_q[8:0];
        state_d = S_DATA;
      end
      S_DATA: if (w_hs) begin
        beat_d = beat_q - 9'd1;
        if (beat_q == 9'd1) state_d = S_RESP;
      end
      S_RESP: if (M_AXI_BVALID) begin
        // SLVERR and DECERR both count; the span carries on regardless.
        err_d  = err_q | (M_AXI_BRESP >= 2'b10);
        addr_d = next_addr;
        rem_d  = next_rem;
        if (next_rem != 12'd0) begin
          blen_n   = calc_blen(next_addr[11:2], next_rem);
          blen_d   = blen_n;
          awaddr_d = next_addr;
          awlen_d  = blen_n[7:0] - 8'd1;
          state_d  = S_ADDR;
        end else state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      blen_q   <= '0;
      beat_q   <= '0;
      awaddr_q <= '0;
      awlen_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      blen_q   <= blen_d;
      beat_q   <= beat_d;
      awaddr_q <= awaddr_d;
      awlen_q  <= awlen_d;
      err_q    <= err_d;
    end
  end

  assign REQ_READY     = (state_q == S_IDLE);
  assign BUSY          = (state_q != S_IDLE);
  assign DONE          = (state_q == S_FIN);
  assign M_AXI_AWVALID = (state_q == S_ADDR);
  assign M_AXI_BREADY  = (state_q == S_RESP);
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWLEN   = awlen_q;
  assign ERR           = err_q;

  // W is a pure pass-through of the pixel stream while in DATA.
  assign M_AXI_WVALID  = (state_q == S_DATA) && DIN_VALID;
  assign DIN_READY     = (state_q == S_DATA) && M_AXI_WREADY;
  assign M_AXI_WDATA   = DIN_DATA;
  assign M_AXI_WSTRB   = DIN_STRB;
  assign M_AXI_WLAST   = (state_q == S_DATA) && (beat_q == 9'd1);
endmodule

// File: tb/tb_draw_wburst.sv
// Bench for draw_wburst: table of spans with expected bursts, AXI slave and
// pixel producer models, and a negedge monitor checking against queues.
module tb_draw_wburst;
  logic        ACLK = 1'b0, ARESETN = 1'b0;
  logic        REQ_VALID = 1'b0, REQ_READY;
  logic [31:0] REQ_ADDR = '0;
  logic [11:0] REQ_WORDS = '0;
  logic        DIN_VALID = 1'b0, DIN_READY;
  logic [31:0] DIN_DATA = '0;
  logic [3:0]  DIN_STRB = '0;
  logic [31:0] AWADDR, WDATA;
  logic [7:0]  AWLEN;
  logic        AWVALID, AWREADY = 1'b0;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY = 1'b0;
  logic [1:0]  BRESP = '0;
  logic        BVALID = 1'b0, BREADY, BUSY, DONE, ERR;

  always #5 ACLK = ~ACLK;

  draw_wburst #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_MAX_BURST(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR), .REQ_WORDS(REQ_WORDS),
    .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY), .DIN_DATA(DIN_DATA), .DIN_STRB(DIN_STRB),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST), .M_AXI_WVALID(WVALID),
    .M_AXI_WREADY(WREADY), .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR));

  typedef struct {
    logic [31:0]      addr;
    logic [11:0]      words;
    int               nb;
    logic [3:0][31:0] aw_addr;
    logic [3:0][7:0]  aw_len;
    int               bad;
    logic             exp_err;
    logic             bp;
  } span_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_t;

  span_t v[7];
  aw_t   aw_q[$];
  w_t    w_q[$];
  w_t    din_q[$];

  int   checks = 0, errors = 0, cyc = 0;
  int   aw_wait = 0, aw_delay = 0, b_issue = 0, bad_burst = -1;
  int   w_beats = 0, done_cnt = 0, done_cyc = 0, b_cyc = 0;
  logic bp = 1'b0, b_pend = 1'b0, din_hs = 1'b0, b_hs = 1'b0, bready_due = 1'b0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic fail(input string n);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur as expected", n);
  endtask

  task automatic nclk;
    @(negedge ACLK);
    #1;
  endtask

  task automatic setv(input int i, input logic [31:0] a, input logic [11:0] w, input int nb,
                      input logic [31:0] a0, input logic [7:0] l0, input logic [31:0] a1,
                      input logic [7:0] l1, input logic [31:0] a2, input logic [7:0] l2,
                      input logic [31:0] a3, input logic [7:0] l3, input int bad,
                      input logic er, input logic b);
    v[i].addr = a; v[i].words = w; v[i].nb = nb;
    v[i].aw_addr = {a3, a2, a1, a0};
    v[i].aw_len  = {l3, l2, l1, l0};
    v[i].bad = bad; v[i].exp_err = er; v[i].bp = b;
  endtask

  // AXI slave and pixel producer; all updates 1 time unit after the rising edge.
  task automatic drv_loop;
    forever begin
      @(posedge ACLK);
      #1;
      if (!ARESETN) begin
        AWREADY = 0; aw_wait = 0; WREADY = 0; BVALID = 0; BRESP = 0; b_pend = 0; DIN_VALID = 0;
      end else begin
        if (AWVALID && !AWREADY) begin
          if (aw_wait >= aw_delay) AWREADY = 1;
          else aw_wait++;
        end else begin
          AWREADY = 0;
          aw_wait = 0;
        end
        WREADY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (b_hs) BVALID = 0;
        if (b_pend) begin
          BVALID = 1;
          BRESP  = (b_issue == bad_burst) ? 2'b10 : {1'b0, bp};
          b_issue++;
          b_pend = 0;
        end
        if (din_hs) begin
          DIN_VALID = 0;
          void'(din_q.pop_front());
        end
        if (!DIN_VALID && din_q.size() > 0 && (!bp || $urandom_range(0, 2) != 0)) begin
          DIN_VALID = 1;
          DIN_DATA  = din_q[0].data;
          DIN_STRB  = din_q[0].strb;
        end
      end
    end
  endtask

  task automatic mon_loop;
    forever begin
      @(negedge ACLK);
      cyc++;
      din_hs = DIN_VALID && DIN_READY;
      b_hs   = BVALID && BREADY;
      if (ARESETN) begin
        if (bready_due) begin
          chk("bready_lat", 32'(BREADY), 1);
          bready_due = 0;
        end
        if (AWVALID) begin
          if (aw_q.size() == 0) fail("aw_unexpected");
          else begin
            chk("awaddr", AWADDR, aw_q[0].addr);
            chk("awlen", 32'(AWLEN), 32'(aw_q[0].len));
            if (AWREADY) void'(aw_q.pop_front());
          end
        end
        if (WVALID && WREADY) begin
          if (w_q.size() == 0) fail("w_unexpected");
          else begin
            chk("wdata", WDATA, w_q[0].data);
            chk("wstrb", 32'(WSTRB), 32'(w_q[0].strb));
            chk("wlast", 32'(WLAST), 32'(w_q[0].last));
            void'(w_q.pop_front());
          end
          w_beats++;
          if (WLAST) begin
            b_pend = 1;
            bready_due = 1;
          end
        end
        if (b_hs) b_cyc = cyc;
        if (DONE) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  endtask

  task automatic request(input logic [31:0] a, input logic [11:0] w);
    int t = 0;
    @(posedge ACLK);
    #1;
    REQ_VALID = 1; REQ_ADDR = a; REQ_WORDS = w;
    nclk;
    while (!REQ_READY && t < 100) begin
      nclk;
      t++;
    end
    if (!REQ_READY) fail("req_timeout");
    @(posedge ACLK);
    #1;
    REQ_VALID = 0;
  endtask

  task automatic load_span(input int i);
    w_t  e;
    aw_t a;
    bp = v[i].bp; aw_delay = v[i].bp ? 5 : 0; bad_burst = v[i].bad; b_issue = 0; w_beats = 0;
    for (int b = 0; b < v[i].nb; b++) begin
      a.addr = v[i].aw_addr[b];
      a.len  = v[i].aw_len[b];
      aw_q.push_back(a);
      for (int k = 0; k <= int'(v[i].aw_len[b]); k++) begin
        e.data = $urandom;
        e.strb = v[i].bp ? 4'($urandom_range(0, 15)) : 4'hf;
        e.last = (k == int'(v[i].aw_len[b]));
        w_q.push_back(e);
        din_q.push_back(e);
      end
    end
  endtask

  task automatic run_span(input int i);
    int t = 0;
    int d0;
    load_span(i);
    d0 = done_cnt;
    request(v[i].addr, v[i].words);
    nclk;
    chk("awvalid_lat", 32'(AWVALID), 1);
    chk("busy", 32'(BUSY), 1);
    while (done_cnt == d0 && t < 3000) begin
      nclk;
      t++;
    end
    if (done_cnt == d0) fail("done_timeout");
    else begin
      chk("done_lat", 32'(done_cyc - b_cyc), 1);
      chk("err", 32'(ERR), 32'(v[i].exp_err));
      chk("aw_left", 32'(aw_q.size()), 0);
      chk("w_left", 32'(w_q.size()), 0);
    end
    nclk;
    chk("idle_busy", 32'(BUSY), 0);
    chk("idle_ready", 32'(REQ_READY), 1);
  endtask

  initial begin
    int t;
    setv(0, 32'h1000_0004, 12'd1, 1, 32'h1000_0004, 8'd0, 0, 0, 0, 0, 0, 0, -1, 0, 0);
    setv(1, 32'h2000_0000, 12'd40, 3, 32'h2000_0000, 8'd15, 32'h2000_0040, 8'd15,
         32'h2000_0080, 8'd7, 0, 0, -1, 0, 0);
    setv(2, 32'h2000_0FF0, 12'd10, 2, 32'h2000_0FF0, 8'd3, 32'h2000_1000, 8'd5, 0, 0, 0, 0, -1, 0, 0);
    setv(3, 32'h3000_0000, 12'd64, 4, 32'h3000_0000, 8'd15, 32'h3000_0040, 8'd15,
         32'h3000_0080, 8'd15, 32'h3000_00C0, 8'd15, -1, 0, 1);
    setv(4, 32'h4000_0002, 12'd20, 2, 32'h4000_0000, 8'd15, 32'h4000_0040, 8'd3, 0, 0, 0, 0, 1, 1, 0);
    setv(5, 32'h5000_0FFC, 12'd2, 2, 32'h5000_0FFC, 8'd0, 32'h5000_1000, 8'd0, 0, 0, 0, 0, -1, 0, 1);
    setv(6, 32'hFFFF_FFF8, 12'd4, 2, 32'hFFFF_FFF8, 8'd1, 32'h0000_0000, 8'd1, 0, 0, 0, 0, -1, 0, 0);

    fork
      drv_loop();
      mon_loop();
    join_none

    repeat (3) @(posedge ACLK);
    nclk;
    chk("rst_req_ready", 32'(REQ_READY), 1);
    chk("rst_awvalid", 32'(AWVALID), 0);
    chk("rst_wvalid", 32'(WVALID), 0);
    chk("rst_wlast", 32'(WLAST), 0);
    chk("rst_bready", 32'(BREADY), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_err", 32'(ERR), 0);
    chk("rst_awaddr", AWADDR, 0);
    chk("rst_awlen", 32'(AWLEN), 0);
    ARESETN = 1;
    repeat (2) nclk;

    for (int i = 0; i <= 4; i++) run_span(i);
    nclk;
    chk("err_hold", 32'(ERR), 1);

    // Zero-length span: DONE next cycle, no AW, and the stale ERR is cleared.
    request(32'h7000_0000, 12'd0);
    nclk;
    chk("zl_done", 32'(DONE), 1);
    chk("zl_awvalid", 32'(AWVALID), 0);
    chk("zl_err_clr", 32'(ERR), 0);
    nclk;
    chk("zl_done_pulse", 32'(DONE), 0);
    chk("zl_ready", 32'(REQ_READY), 1);
    chk("zl_awvalid2", 32'(AWVALID), 0);

    run_span(5);
    run_span(6);

    // Reset during beat 3 of a 16-beat burst.
    bp = 0; aw_delay = 0; bad_burst = -1; b_issue = 0; w_beats = 0;
    aw_q.push_back('{addr: 32'h6000_0000, len: 8'd15});
    for (int k = 0; k < 16; k++) begin
      w_q.push_back('{data: 32'hA5A5_0000 + 32'(k), strb: 4'hf, last: (k == 15)});
      din_q.push_back('{data: 32'hA5A5_0000 + 32'(k), strb: 4'hf, last: (k == 15)});
    end
    request(32'h6000_0000, 12'd16);
    t = 0;
    while (w_beats < 2 && t < 200) begin
      nclk;
      t++;
    end
    if (w_beats < 2) fail("rst_beats_timeout");
    @(posedge ACLK);
    #2;
    chk("pre_rst_wvalid", 32'(WVALID), 1);
    ARESETN = 0;
    #1;
    chk("midrst_wvalid", 32'(WVALID), 0);
    chk("midrst_awvalid", 32'(AWVALID), 0);
    chk("midrst_busy", 32'(BUSY), 0);
    chk("midrst_din_ready", 32'(DIN_READY), 0);
    aw_q.delete(); w_q.delete(); din_q.delete(); bready_due = 0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    ARESETN = 1;
    nclk;
    chk("post_rst_ready", 32'(REQ_READY), 1);
    chk("post_rst_busy", 32'(BUSY), 0);
    chk("post_rst_awvalid", 32'(AWVALID), 0);
    run_span(0);
    run_span(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/draw_wburst.md
# draw_wburst

AXI4 write-burst engine for the draw pipeline. It sits directly downstream of the command execution stage. It accepts a span request (start VRAM byte address plus word count) and a 32-bit pixel-word stream, and emits AXI4 write transactions on the master AW/W/B channels. Spans are split so that no burst exceeds C_MAX_BURST beats or crosses a 4 KB boundary. One burst is outstanding at a time.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported
- C_MAX_BURST, 16, maximum beats per burst; must be a power of 2 in the range 1..256

Ports:
- ACLK  in  1  clock; all logic on the rising edge
- ARESETN  in  1  reset, asynchronous, active-low
- REQ_VALID  in  1  span request valid
- REQ_READY  out  1  span request accepted when this and REQ_VALID are both 1
- REQ_ADDR  in  32  span start byte address; bits [1:0] are ignored and treated as 0
- REQ_WORDS  in  12  span length in 32-bit words, 0..4095
- DIN_VALID  in  1  pixel word valid
- DIN_READY  out  1  pixel word consumed
- DIN_DATA  in  32  pixel word
- DIN_STRB  in  4  byte enables for the pixel word
- M_AXI_AWADDR  out  32  burst address
- M_AXI_AWLEN  out  8  beats − 1
- M_AXI_AWVALID  out  1  AW valid
- M_AXI_AWREADY  in  1  AW ready
- M_AXI_WDATA  out  32  write data
- M_AXI_WSTRB  out  4  write strobes
- M_AXI_WLAST  out  1  last beat of the burst
- M_AXI_WVALID  out  1  W valid
- M_AXI_WREADY  in  1  W ready
- M_AXI_BRESP  in  2  write response
- M_AXI_BVALID  in  1  B valid
- M_AXI_BREADY  out  1  B ready
- BUSY  out  1  span in progress
- DONE  out  1  one-cycle pulse when a span completes
- ERR  out  1  sticky flag: at least one BRESP[1]=1 seen during the current span

## Operation
- States: IDLE, ADDR, DATA, RESP, FIN.
- IDLE:
  - REQ_READY=1.
  - On accept, latch addr = {REQ_ADDR[31:2],2'b00} and rem = REQ_WORDS, and clear ERR.
  - If REQ_WORDS=0, go to FIN with no AXI traffic. Otherwise go to ADDR.
- Burst length, computed on entry to ADDR:
  - blen = min(rem, C_MAX_BURST, 1024 − addr[11:2]).
  - Compute blen with 11-bit unsigned arithmetic.
  - AWADDR = addr, AWLEN = blen − 1.
- ADDR:
  - AWVALID=1, with AWADDR/AWLEN held stable until AWREADY.
  - On the handshake, go to DATA and load beat counter = blen.
- DATA: W channel passes straight through from the pixel stream.
  - WVALID = DIN_VALID.
  - DIN_READY = WREADY.
  - WDATA = DIN_DATA, WSTRB = DIN_STRB.
  - WLAST = (beat counter = 1).
  - Each W handshake decrements the beat counter.
  - The handshake with WLAST=1 moves the FSM to RESP.
  - Outside DATA: WVALID=0, DIN_READY=0, WLAST=0.
- RESP:
  - BREADY=1.
  - On BVALID:
    - If BRESP[1]=1, set ERR.
    - addr += blen×4, rem −= blen.
    - If rem>0, go to ADDR; otherwise go to FIN.
- FIN: DONE=1 for one cycle, then go to IDLE.
- BUSY=1 in every state except IDLE.
- ERR holds its value after DONE until the next request is accepted. An error response does not abort the span.
- Address arithmetic is 32-bit and wraps modulo 2^32 with no error flagged.

## Timing
- Reset values: REQ_READY=1 (combinational, state=IDLE).
- Reset values: AWVALID=0, WVALID=0, WLAST=0, BREADY=0, BUSY=0, DONE=0, ERR=0, AWADDR=0, AWLEN=0.
- ARESETN low forces IDLE immediately (asynchronously), including mid-burst. There is no attempt to complete the AXI transaction. The bench must reset the slave too.
- Request accepted in cycle N: AWVALID=1 in cycle N+1.
- AW handshake in cycle M: DATA from M+1; WVALID may rise in M+1.
- Last W handshake in cycle K: BREADY=1 in K+1.
- B handshake in cycle R: next AWVALID in R+1, or DONE in R+1.
- Zero-length request accepted in N: DONE=1 in N+1, then REQ_READY=1 in N+2.
- AWVALID, once asserted, is never dropped before AWREADY.
- AWADDR and AWLEN are registered outputs.
- W and DIN handshakes occur in the same cycle; no data is buffered inside the block.
- DIN_VALID is ignored in IDLE/ADDR/RESP/FIN. The producer stalls via DIN_READY=0.

## Test plan
- Single word:
  - Stimulus: REQ_ADDR=0x1000_0004, WORDS=1.
  - Required response: AWADDR=0x1000_0004, AWLEN=0; one beat with WLAST=1; DONE 1 cycle after B; ERR=0.
- Max-burst split:
  - Stimulus: addr=0x2000_0000, WORDS=40, C_MAX_BURST=16.
  - Required response: three bursts, AWADDR=0x2000_0000/0x040/0x080 with AWLEN=15/15/7; WLAST on beats 16, 32, 40.
- 4 KB crossing:
  - Stimulus: addr=0x2000_0FF0, WORDS=10.
  - Required response: burst AWADDR=0x2000_0FF0 with AWLEN=3, then AWADDR=0x2000_1000 with AWLEN=5.
- Backpressure:
  - Stimulus: AWREADY delayed 5 cycles; WREADY random 50%; DIN_VALID random gaps; 64 words.
  - Required response: AWADDR/AWLEN stable while AWVALID=1; all 64 DIN words appear on WDATA in order with matching WSTRB.
- Error and zero-length:
  - Stimulus: WORDS=20 with BRESP=2'b10 on the 2nd burst only.
  - Required response: both bursts complete, ERR=1 at DONE; next request clears ERR.
  - Stimulus: WORDS=0.
  - Required response: DONE in N+1, no AWVALID.
- Reset mid-DATA:
  - Stimulus: ARESETN low during beat 3 of 16.
  - Required response: WVALID/AWVALID/BUSY go to 0 in the same cycle; after release REQ_READY=1 and a new span completes normally.
